// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: 4-slot time-division arbiter sharing one single-port
// frame-buffer RAM between VGA scan-out (slot 0) and a pixel writer
// (slots 1..3). Also produces the 25 MHz pixel clock-enable.
// Optional build macro VGA_FB_BLANK_WRITE_EN: slot 0 becomes a writer slot
// while the display is blanked.
module vga_fb_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              CLK_100M,
    input  logic              RST,
    output logic              pix_ce,
    input  logic              disp_active,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              wr_cnt_clr,
    output logic [CNT_W-1:0]  wr_wait_cnt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {PH_DISP = 2'd0, PH_W1 = 2'd1, PH_W2 = 2'd2, PH_W3 = 2'd3} ph_e;
    typedef enum logic [1:0] {SL_IDLE, SL_READ, SL_WRITE} slot_e;

    ph_e               ph_q, ph_d;
    slot_e             slot;
    logic              rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Slot-frame state register plus the registered read-return and stall counter
    always_ff @(posedge CLK_100M or posedge RST) begin
        if (RST) begin
            ph_q        <= PH_DISP;
            rd_pend_q   <= 1'b0;
            disp_data_q <= '0;
            cnt_q       <= '0;
        end else begin
            ph_q        <= ph_d;
            rd_pend_q   <= rd_pend_d;
            disp_data_q <= disp_data_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next phase, slot ownership, RAM port steering and read-return / counter next state
    always_comb begin
        ph_d        = PH_DISP;
        slot        = SL_IDLE;
        rd_pend_d   = rd_pend_q;
        disp_data_d = disp_data_q;
        cnt_d       = cnt_q;

        case (ph_q)
            PH_DISP: ph_d = PH_W1;
            PH_W1:   ph_d = PH_W2;
            PH_W2:   ph_d = PH_W3;
            default: ph_d = PH_DISP;
        endcase

        // Display owns slot 0 outright when visible; a writer waiting there stalls
        if (ph_q == PH_DISP) begin
            if (disp_active) begin
                slot = SL_READ;
            end
`ifdef VGA_FB_BLANK_WRITE_EN
            else if (wr_req) begin
                slot = SL_WRITE;
            end
`endif
        end else if (wr_req) begin
            slot = SL_WRITE;
        end

        // Held in reset: nothing may reach the RAM, so a pending write is dropped
        if (RST) begin
            slot = SL_IDLE;
        end

        if (slot == SL_READ) begin
            rd_pend_d = 1'b1;
        end

        // RAM data for the slot-0 read is on ram_rdata during slot 1
        if (ph_q == PH_W1) begin
            disp_data_d = rd_pend_q ? ram_rdata : '0;
            rd_pend_d   = 1'b0;
        end

        if (wr_cnt_clr) begin
            cnt_d = '0;
        end else if (wr_req && (slot != SL_WRITE) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign ram_addr    = (slot == SL_WRITE) ? wr_addr : disp_addr;
    assign ram_wdata   = wr_data;
    assign ram_we      = (slot == SL_WRITE);
    assign wr_ack      = (slot == SL_WRITE);
    assign pix_ce      = (ph_q == PH_W3);
    assign disp_data   = disp_data_q;
    assign wr_wait_cnt = cnt_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural 1-cycle-latency RAM.
module tb_vga_fb_arbiter;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              CLK_100M = 1'b0;
    logic              RST = 1'b1;
    logic              pix_ce;
    logic              disp_active = 1'b0;
    logic [ADDR_W-1:0] disp_addr = '0;
    logic [DATA_W-1:0] disp_data;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_ack;
    logic              wr_cnt_clr = 1'b0;
    logic [CNT_W-1:0]  wr_wait_cnt;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    vga_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .CLK_100M(CLK_100M), .RST(RST), .pix_ce(pix_ce),
        .disp_active(disp_active), .disp_addr(disp_addr), .disp_data(disp_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .wr_cnt_clr(wr_cnt_clr), .wr_wait_cnt(wr_wait_cnt),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    always #5 CLK_100M = ~CLK_100M;

    // Frame-buffer RAM model: synchronous write, registered read
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge CLK_100M) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Bench-side slot phase, reset the same way the arbiter's is
    logic [1:0] tb_ph;
    always @(posedge CLK_100M or posedge RST) begin
        if (RST) tb_ph <= 2'd0;
        else     tb_ph <= tb_ph + 2'd1;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK_100M);
        #2;
    endtask

    task automatic goto_ph(input logic [1:0] p);
        wr_req = 1'b0;
        for (int i = 0; i < 4 && tb_ph != p; i++) step();
        chk("goto_ph", {30'd0, tb_ph}, {30'd0, p});
    endtask

    task automatic clr_cnt();
        wr_cnt_clr = 1'b1;
        step();
        wr_cnt_clr = 1'b0;
        chk("cnt_clr", wr_wait_cnt, 0);
    endtask

    typedef struct {
        logic [1:0]        ph;
        logic              da;
        logic              req;
        logic [ADDR_W-1:0] daddr;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic [ADDR_W-1:0] e_addr;
        logic              e_we;
        logic              e_pce;
    } vec_t;

    vec_t tv [8];
    logic [1:0] eph [4];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = '0;
        mem[15'h1234] = 8'hA5;
        mem[15'h2000] = 8'h3C;

        // ph, da, req, daddr, waddr, wdata, exp addr, exp we/ack, exp pix_ce
        tv[0] = '{2'd0, 1'b1, 1'b0, 15'h1234, 15'h0100, 8'h5A, 15'h1234, 1'b0, 1'b0};
        tv[1] = '{2'd0, 1'b1, 1'b1, 15'h1234, 15'h0100, 8'h5A, 15'h1234, 1'b0, 1'b0};
        tv[2] = '{2'd1, 1'b1, 1'b1, 15'h1234, 15'h0100, 8'h5A, 15'h0100, 1'b1, 1'b0};
        tv[3] = '{2'd2, 1'b0, 1'b0, 15'h0777, 15'h0100, 8'h5A, 15'h0777, 1'b0, 1'b0};
        tv[4] = '{2'd3, 1'b1, 1'b1, 15'h1234, 15'h7FFF, 8'hFF, 15'h7FFF, 1'b1, 1'b1};
`ifdef VGA_FB_BLANK_WRITE_EN
        tv[5] = '{2'd0, 1'b0, 1'b1, 15'h0300, 15'h0200, 8'hC3, 15'h0200, 1'b1, 1'b0};
`else
        tv[5] = '{2'd0, 1'b0, 1'b1, 15'h0300, 15'h0200, 8'hC3, 15'h0300, 1'b0, 1'b0};
`endif
        tv[6] = '{2'd3, 1'b0, 1'b0, 15'h0ABC, 15'h0200, 8'hC3, 15'h0ABC, 1'b0, 1'b1};
        tv[7] = '{2'd2, 1'b1, 1'b1, 15'h0001, 15'h0002, 8'hEE, 15'h0002, 1'b1, 1'b0};
        eph[0] = 2'd1; eph[1] = 2'd2; eph[2] = 2'd3; eph[3] = 2'd1;

        // Reset state and pix_ce cadence after release
        repeat (2) @(posedge CLK_100M);
        #2;
        chk("rst_pix_ce", pix_ce, 0);
        chk("rst_wr_ack", wr_ack, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_disp_data", disp_data, 0);
        chk("rst_cnt", wr_wait_cnt, 0);
        RST = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1 chk($sformatf("pix_ce_cyc%0d", i + 1), pix_ce, (i % 4) == 3);
            step();
        end

        // Combinational slot steering vectors
        for (int i = 0; i < 8; i++) begin
            goto_ph(tv[i].ph);
            disp_active = tv[i].da;
            wr_req      = tv[i].req;
            disp_addr   = tv[i].daddr;
            wr_addr     = tv[i].waddr;
            wr_data     = tv[i].wdata;
            #1;
            chk($sformatf("tv%0d_ram_addr", i), ram_addr, tv[i].e_addr);
            chk($sformatf("tv%0d_ram_we", i), ram_we, tv[i].e_we);
            chk($sformatf("tv%0d_wr_ack", i), wr_ack, tv[i].e_we);
            chk($sformatf("tv%0d_pix_ce", i), pix_ce, tv[i].e_pce);
            if (tv[i].e_we) chk($sformatf("tv%0d_ram_wdata", i), ram_wdata, tv[i].wdata);
            step();
        end
        wr_req = 1'b0;
        chk("tv_mem_0100", mem[15'h0100], 8'h5A);
        chk("tv_mem_7fff", mem[15'h7FFF], 8'hFF);
        clr_cnt();

        // Display fetch and hold across pix_ce
        goto_ph(2'd0);
        disp_active = 1'b1;
        disp_addr   = 15'h1234;
        #1;
        chk("fetch_ram_addr", ram_addr, 15'h1234);
        chk("fetch_ram_we", ram_we, 0);
        step(); step();
        chk("fetch_data_s2", disp_data, 8'hA5);
        step();
        chk("fetch_pix_ce_s3", pix_ce, 1);
        chk("fetch_data_s3", disp_data, 8'hA5);
        step();
        disp_addr = 15'h2000;
        chk("fetch_data_s0", disp_data, 8'hA5);
        step();
        chk("fetch_data_s1", disp_data, 8'hA5);
        step();
        chk("fetch2_data_s2", disp_data, 8'h3C);

        // Back-to-back writes in active video
        clr_cnt();
        goto_ph(2'd1);
        disp_addr = 15'h1234;
        for (int k = 0; k < 4; k++) begin
            wr_req  = 1'b1;
            wr_addr = ADDR_W'(k + 1);
            wr_data = DATA_W'((k + 1) * 17);
            got = 1'b0;
            for (int c = 0; c < 8; c++) begin
                #1;
                if (wr_ack) begin
                    got = 1'b1;
                    break;
                end
                step();
            end
            chk($sformatf("b2b_ack%0d_ph", k), got ? {30'd0, tb_ph} : 32'hDEAD, {30'd0, eph[k]});
            step();
        end
        wr_req = 1'b0;
        chk("b2b_cnt", wr_wait_cnt, 1);
        chk("b2b_mem1", mem[15'h0001], 8'h11);
        chk("b2b_mem2", mem[15'h0002], 8'h22);
        chk("b2b_mem3", mem[15'h0003], 8'h33);
        chk("b2b_mem4", mem[15'h0004], 8'h44);

        // Write request rising in slot 0 during active video
        clr_cnt();
        goto_ph(2'd0);
        disp_active = 1'b1;
        disp_addr   = 15'h1234;
        wr_req      = 1'b1;
        wr_addr     = 15'h0050;
        wr_data     = 8'h77;
        #1;
        chk("conf_s0_addr", ram_addr, 15'h1234);
        chk("conf_s0_ack", wr_ack, 0);
        chk("conf_s0_we", ram_we, 0);
        step();
        chk("conf_s1_ack", wr_ack, 1);
        chk("conf_s1_addr", ram_addr, 15'h0050);
        step();
        wr_req = 1'b0;
        chk("conf_cnt", wr_wait_cnt, 1);
        chk("conf_mem", mem[15'h0050], 8'h77);
        chk("conf_disp_data", disp_data, 8'hA5);

        // Blanking with writer pending in slot 0
        clr_cnt();
        goto_ph(2'd0);
        disp_active = 1'b0;
        disp_addr   = 15'h1234;
        wr_req      = 1'b1;
        wr_addr     = 15'h0060;
        wr_data     = 8'h99;
        #1;
`ifdef VGA_FB_BLANK_WRITE_EN
        chk("blank_s0_ack", wr_ack, 1);
        chk("blank_s0_we", ram_we, 1);
        chk("blank_s0_addr", ram_addr, 15'h0060);
        step();
        wr_req = 1'b0;
        step();
        chk("blank_disp_data", disp_data, 0);
        chk("blank_cnt", wr_wait_cnt, 0);
`else
        chk("blank_s0_ack", wr_ack, 0);
        chk("blank_s0_we", ram_we, 0);
        chk("blank_s0_addr", ram_addr, 15'h1234);
        step();
        chk("blank_s1_ack", wr_ack, 1);
        step();
        wr_req = 1'b0;
        chk("blank_disp_data", disp_data, 0);
        chk("blank_cnt", wr_wait_cnt, 1);
`endif
        chk("blank_mem", mem[15'h0060], 8'h99);

        // Stall counter saturation and clear-over-increment priority
        clr_cnt();
        goto_ph(2'd0);
`ifdef VGA_FB_BLANK_WRITE_EN
        disp_active = 1'b1;
`else
        disp_active = 1'b0;
`endif
        wr_req  = 1'b1;
        wr_addr = 15'h0061;
        wr_data = 8'h55;
        repeat (14 * 4) step();
        chk("sat_cnt14", wr_wait_cnt, 14);
        repeat (26 * 4) step();
        chk("sat_cnt15", wr_wait_cnt, 15);
        chk("sat_at_ph0", {30'd0, tb_ph}, 0);
        wr_cnt_clr = 1'b1;
        step();
        wr_cnt_clr = 1'b0;
        wr_req     = 1'b0;
        chk("sat_clr_prio", wr_wait_cnt, 0);

        // Reset asserted mid-frame with an un-acked write on the port
        goto_ph(2'd0);
        disp_active = 1'b1;
        disp_addr   = 15'h1234;
        wr_req      = 1'b1;
        wr_addr     = 15'h0071;
        wr_data     = 8'h01;
        step(); step();
        wr_addr = 15'h0070;
        wr_data = 8'h12;
        #1;
        chk("prerst_disp_data", disp_data, 8'hA5);
        chk("prerst_cnt", wr_wait_cnt, 1);
        chk("prerst_ack", wr_ack, 1);
        RST = 1'b1;
        #1;
        chk("midrst_pix_ce", pix_ce, 0);
        chk("midrst_ack", wr_ack, 0);
        chk("midrst_we", ram_we, 0);
        chk("midrst_disp_data", disp_data, 0);
        chk("midrst_cnt", wr_wait_cnt, 0);
        step(); step();
        RST    = 1'b0;
        wr_req = 1'b0;
        chk("midrst_no_write", mem[15'h0070], 8'h00);
        for (int i = 0; i < 12; i++) begin
            #1 chk($sformatf("rel_pix_ce_cyc%0d", i + 1), pix_ce, (i % 4) == 3);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Time-division arbiter that shares one single-port synchronous frame-buffer RAM (RGB332 pixels) between the VGA scan-out path and a pixel writer (drawing engine / host). It runs on the 100 MHz system clock and divides it into a fixed 4-cycle slot frame that also produces the 25 MHz pixel clock-enable for the VGA timing generator. Display reads have absolute priority in their slot. The writer uses a req/ack handshake in the remaining slots.

## Interface
- ADDR_W, 15, frame-buffer word address width (160x120 = 19200 pixels).
- DATA_W, 8, pixel width (RGB332: red[7:5], green[4:2], blue[1:0]).
- CNT_W, 16, width of stall statistics counter.

- CLK_100M  in  1  system clock, 100 MHz.
- RST  in  1  reset; asynchronous, active-high.
- pix_ce  out  1  pixel clock-enable to timing generator, high when phase==3.
- disp_active  in  1  timing generator in visible area.
- disp_addr  in  ADDR_W  pixel address to fetch; must be stable during phase 0.
- disp_data  out  DATA_W  fetched pixel, registered.
- wr_req  in  1  writer request; held with wr_addr/wr_data stable until wr_ack.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ack  out  1  one-cycle grant; the write is performed in this cycle.
- wr_cnt_clr  in  1  synchronous clear of wr_wait_cnt.
- wr_wait_cnt  out  CNT_W  saturating count of stalled writer cycles.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  DATA_W  RAM read data, registered, 1-cycle latency.

## Operation
- 2-bit free-running phase counter ph: 0,1,2,3,0,… Reset value 0.
- Slot 0 (display slot): if disp_active=1, then ram_addr=disp_addr and ram_we=0. A read-pending flag is set. Otherwise the slot is idle, unless VGA_FB_BLANK_WRITE_EN is defined.
- Slots 1,2,3 (writer slots): if wr_req=1, then ram_addr=wr_addr, ram_wdata=wr_data, ram_we=1 and wr_ack=1.
- In an idle slot, ram_we=0 and ram_addr=disp_addr.
- RAM port outputs and wr_ack are combinational from ph, disp_active, wr_req and the input buses. They are glitch-free relative to the CLK_100M edge.
- Read return: at the edge ending slot 1, disp_data <= ram_rdata if the read-pending flag is set. Otherwise disp_data <= 0 (black during blanking). The read-pending flag is then cleared.
- Writer handshake: a write is complete in the wr_ack cycle. If wr_req stays high in the next cycle, that is a new request. Back-to-back writes are therefore possible in slots 1,2,3. The writer never gets two acks for one request.
- wr_wait_cnt: +1 each cycle with wr_req=1 and wr_ack=0. It saturates at 2^CNT_W-1. wr_cnt_clr has priority over increment.
- A display read and a write never occur in the same cycle.

## Timing
- Reset values: ph=0, disp_data=0, read-pending=0, wr_wait_cnt=0, pix_ce=0, wr_ack=0, ram_we=0.
- pix_ce is first high in the 4th cycle after RST deasserts, then every 4 cycles.
- Display latency: address presented in slot 0; disp_data is valid from slot 2 through slot 1 of the next frame. It is stable when pix_ce is high.
- Writer latency:
  - request present in slots 1–3: 0 cycles;
  - request rising in slot 0 during active video: 1 cycle.
- Worst-case writer throughput: 3 writes per 4 cycles.
- Reset mid-operation: outputs clear immediately. A request not yet acked is not performed, and the writer re-presents it. A read in flight is discarded.

## Configuration
- VGA_FB_BLANK_WRITE_EN defined: slot 0 with disp_active=0 is a writer slot with the same rules as slots 1–3. Writer throughput during blanking is 4 writes per 4 cycles.
- Not defined: slot 0 is always idle during blanking, and wr_req=1 there counts as a stall.

## Test plan
- Reset: assert RST mid-frame with wr_req=1. All outputs go to their reset values at once, and wr_wait_cnt=0. After release, pix_ce pulses on cycles 4, 8, 12.
- Display fetch: disp_active=1, disp_addr=0x1234, RAM[0x1234]=0xA5.
  - Slot 0 shows ram_addr=0x1234 with ram_we=0.
  - disp_data=0xA5 from slot 2 and is held across pix_ce.
- Back-to-back writes, active video: wr_req held for 4 writes (0x0001/0x11 … 0x0004/0x44).
  - Acks in slots 1, 2, 3, then slot 1 of the next frame.
  - wr_wait_cnt=1, and the RAM holds all four values.
- Conflict: wr_req rises in slot 0 with disp_active=1. The display read is performed, wr_ack is in slot 1, and wr_wait_cnt increments by 1.
- Blanking, disp_active=0, wr_req high for slot 0:
  - macro off: no ram_we in slot 0, disp_data=0x00 from slot 2;
  - macro on: wr_ack and ram_we in slot 0.
- Saturation: CNT_W=4, wr_req held through 40 display-blocked cycles (macro off, blank) → wr_wait_cnt sticks at 15. wr_cnt_clr for 1 cycle → 0.
